qosc_amp_monitor: RTL and testbench

//  Consumes re/im samples from the quadrature oscillator output stage. Computes |z|^2 = re^2 + im^2

---
 rtl/qosc_pkg.sv | 27 ++
 rtl/qosc_squarer.sv | 20 ++
 rtl/qosc_amp_monitor.sv | 185 ++++++++++++++++++
 tb/tb_qosc_amp_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/qosc_pkg.sv
// Purpose: shared types and default parameters for the quadrature-oscillator amplitude monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro used by the monitor: QOSC_AMP_MON_ZC_EN (zero-crossing counter).
package qosc_pkg;

  localparam int          W_DEF        = 8;
  localparam int          LOG2_WIN_DEF = 4;
  localparam int unsigned TOL_DEF      = 32'h10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQ_RE  = 2'd1,
    SQ_IM  = 2'd2,
    REPORT = 2'd3
  } state_e;

  // Result record at the default widths. The monitor re-declares the same
  // layout at its own parameter widths so non-default builds stay consistent.
  typedef struct packed {
    logic [2*W_DEF-1:0]    mean;
    logic                  low;
    logic                  high;
    logic [LOG2_WIN_DEF-1:0] zc;
  } result_t;

endpackage

// File: rtl/qosc_squarer.sv
// Purpose: combinational square of a signed W-bit value, 2W-bit unsigned result.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a (signed W-bit operand), sq (a*a, unsigned 2W bits).
module qosc_squarer
  import qosc_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic signed [W-1:0]   a,
  output logic        [2*W-1:0] sq
);

  // Largest square is (-2^(W-1))^2 = 2^(2W-2), which is positive in 2W signed bits.
  logic signed [2*W-1:0] prod;

  assign prod = a * a;
  assign sq   = prod;

endmodule

// File: rtl/qosc_amp_monitor.sv
// Purpose: windowed mean of |z|^2 over 2^LOG2_WIN samples, compared against a target power band.
// Latency: 3 cycles per sample; result valid 1 cycle after the last sample's SQ_IM cycle.
// Backpressure: s_ready only in IDLE (1 sample / 3 clocks); result held in REPORT until m_ready.
// Ports: clk, rst_n (async active-low); s_valid/s_ready/s_re/s_im sample input;
//        target power; m_valid/m_ready/m_mean/m_low/m_high/m_zc_count result output.
// Macro QOSC_AMP_MON_ZC_EN enables the positive-going zero-crossing counter on re;
// without it m_zc_count is tied to 0 and no sign/counter registers exist.
module qosc_amp_monitor
  import qosc_pkg::*;
#(
  parameter int          W        = W_DEF,
  parameter int          LOG2_WIN = LOG2_WIN_DEF,
  parameter int unsigned TOL      = TOL_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [W-1:0]   s_re,
  input  logic signed [W-1:0]   s_im,
  input  logic [2*W-1:0]        target,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2*W-1:0]        m_mean,
  output logic                  m_low,
  output logic                  m_high,
  output logic [LOG2_WIN-1:0]   m_zc_count
);

  localparam int                PW       = 2 * W;
  localparam int                SW       = PW + LOG2_WIN;
  localparam logic [PW:0]       TOL_X    = (PW+1)'(TOL);
  localparam logic [PW:0]       PMAX     = {1'b0, {PW{1'b1}}};
  localparam logic [LOG2_WIN-1:0] CNT_LAST = {LOG2_WIN{1'b1}};

  typedef struct packed {
    logic [PW-1:0]       mean;
    logic                low;
    logic                high;
    logic [LOG2_WIN-1:0] zc;
  } res_t;

  state_e                state_q, state_d;
  logic signed [W-1:0]   re_q, re_d;
  logic signed [W-1:0]   im_q, im_d;
  logic [PW-1:0]         tmp_q, tmp_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [LOG2_WIN-1:0]   cnt_q, cnt_d;
  res_t                  res_q, res_d;

  logic signed [W-1:0]   sq_in;
  logic [PW-1:0]         sq_out;
  logic [SW-1:0]         sum_acc;
  logic [PW-1:0]         mean_new;
  logic [PW:0]           tgt_x, lo_bnd, hi_raw, hi_bnd;
  logic [LOG2_WIN-1:0]   zc_cur;

  // One squarer, time-shared: re in SQ_RE, im in SQ_IM.
  assign sq_in = (state_q == SQ_IM) ? im_q : re_q;

  qosc_squarer #(.W(W)) u_sq (
    .a  (sq_in),
    .sq (sq_out)
  );

  // Accumulated sum including the current sample; only meaningful in SQ_IM.
  assign sum_acc  = sum_q + SW'(tmp_q) + SW'(sq_out);
  assign mean_new = sum_acc[SW-1:LOG2_WIN];

  // Tolerance band in 2W+1 bits so both ends saturate instead of wrapping.
  always_comb begin
    tgt_x  = {1'b0, target};
    lo_bnd = (tgt_x >= TOL_X) ? (tgt_x - TOL_X) : '0;
    hi_raw = tgt_x + TOL_X;
    hi_bnd = (hi_raw > PMAX) ? PMAX : hi_raw;
  end

`ifdef QOSC_AMP_MON_ZC_EN
  // Sign history persists across windows; only the count is cleared on report.
  logic                neg_q, neg_d;
  logic [LOG2_WIN-1:0] zc_q, zc_d;

  always_comb begin
    neg_d = neg_q;
    zc_d  = zc_q;
    if (state_q == IDLE && s_valid) begin
      neg_d = s_re[W-1];
      if (neg_q && !s_re[W-1] && (zc_q != CNT_LAST)) begin
        zc_d = zc_q + 1'b1;
      end
    end else if (state_q == REPORT && m_ready) begin
      zc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      zc_q  <= '0;
    end else begin
      neg_q <= neg_d;
      zc_q  <= zc_d;
    end
  end

  assign zc_cur = zc_q;
`else
  assign zc_cur = '0;
`endif

  always_comb begin
    state_d = state_q;
    re_d    = re_q;
    im_d    = im_q;
    tmp_d   = tmp_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    s_ready = 1'b0;
    m_valid = 1'b0;

    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          re_d    = s_re;
          im_d    = s_im;
          state_d = SQ_RE;
        end
      end
      SQ_RE: begin
        tmp_d   = sq_out;
        state_d = SQ_IM;
      end
      SQ_IM: begin
        sum_d = sum_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_d.mean = mean_new;
          res_d.low  = ({1'b0, mean_new} < lo_bnd);
          res_d.high = ({1'b0, mean_new} > hi_bnd);
          res_d.zc   = zc_cur;
          state_d    = REPORT;
        end else begin
          state_d = IDLE;
        end
      end
      REPORT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          sum_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      re_q    <= '0;
      im_q    <= '0;
      tmp_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      re_q    <= re_d;
      im_q    <= im_d;
      tmp_q   <= tmp_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign m_mean     = res_q.mean;
  assign m_low      = res_q.low;
  assign m_high     = res_q.high;
  assign m_zc_count = res_q.zc;

endmodule

// File: tb/tb_qosc_amp_monitor.sv
// Purpose: self-checking bench for qosc_amp_monitor (W=8, LOG2_WIN=2, TOL=0x10).
// Latency: n/a.
// Backpressure: exercises held results (m_ready low) and mid-window reset.
module tb_qosc_amp_monitor;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_re;
  logic [7:0]  s_im;
  logic [15:0] target;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_mean;
  logic        m_low;
  logic        m_high;
  logic [1:0]  m_zc_count;

  int n_cmp = 0;
  int n_err = 0;

  qosc_amp_monitor #(.W(8), .LOG2_WIN(2), .TOL(32'h10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_re       (s_re),
    .s_im       (s_im),
    .target     (target),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_mean     (m_mean),
    .m_low      (m_low),
    .m_high     (m_high),
    .m_zc_count (m_zc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] re;
    logic [3:0][7:0] im;
    logic [15:0]     tgt;
    logic [15:0]     mean;
    logic            low;
    logic            high;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for s_ready at a falling edge, then presents one sample for one rising edge.
  task automatic send(input logic [7:0] re, input logic [7:0] im);
    int t = 0;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      chk("s_ready timeout", {31'd0, s_ready}, 32'd1);
    end else begin
      s_valid = 1'b1;
      s_re    = re;
      s_im    = im;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_result();
    int t = 0;
    @(negedge clk);
    while (!m_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!m_valid) chk("m_valid timeout", {31'd0, m_valid}, 32'd1);
  endtask

  task automatic accept();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] zc_exp;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_re    = '0;
    s_im    = '0;
    target  = '0;
    m_ready = 1'b0;

    //              re x4 (idx0 first)         im x4                      tgt       mean      lo    hi
    vt[0] = '{{4{8'h20}},                 {4{8'h00}}, 16'h0400, 16'h0400, 1'b0, 1'b0};
    vt[1] = '{{4{8'h80}},                 {4{8'h80}}, 16'h0040, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{{4{8'h01}},                 {4{8'h00}}, 16'h0400, 16'h0001, 1'b1, 1'b0};
    vt[3] = '{{4{8'h01}},                 {4{8'h00}}, 16'h0008, 16'h0001, 1'b0, 1'b0};
    vt[4] = '{{4{8'h03}},                 {4{8'h04}}, 16'h0020, 16'h0019, 1'b0, 1'b0};
    vt[5] = '{{8'd4, 8'd3, 8'd2, 8'd1},   {4{8'h00}}, 16'h0017, 16'h0007, 1'b0, 1'b0};
    vt[6] = '{{4{8'h80}},                 {4{8'h80}}, 16'hFFF8, 16'h8000, 1'b1, 1'b0};
    vt[7] = '{{4{8'h03}},                 {4{8'h04}}, 16'h0009, 16'h0019, 1'b0, 1'b0};
    vt[8] = '{{4{8'h03}},                 {4{8'h04}}, 16'h0008, 16'h0019, 1'b0, 1'b1};
    vt[9] = '{{8'd4, 8'd3, 8'd2, 8'd1},   {4{8'h00}}, 16'h0018, 16'h0007, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst m_mean", {16'd0, m_mean}, 32'd0);
    chk("rst m_low", {31'd0, m_low}, 32'd0);
    chk("rst m_high", {31'd0, m_high}, 32'd0);
    chk("rst m_zc", {30'd0, m_zc_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Result latency: m_valid rises the cycle after the 4th sample's SQ_IM
    target = 16'h0400;
    for (int i = 0; i < 4; i++) send(8'h20, 8'h00);
    @(negedge clk);
    chk("lat SQ_RE m_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    chk("lat SQ_IM m_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    chk("lat REPORT m_valid", {31'd0, m_valid}, 32'd1);
    chk("lat m_mean", {16'd0, m_mean}, 32'h400);

    // Hold the result with m_ready low for 5 cycles
    target = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      chk("hold m_valid", {31'd0, m_valid}, 32'd1);
      chk("hold s_ready", {31'd0, s_ready}, 32'd0);
      chk("hold m_mean", {16'd0, m_mean}, 32'h400);
      chk("hold m_low", {31'd0, m_low}, 32'd0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk("post-accept m_valid", {31'd0, m_valid}, 32'd0);
    chk("post-accept s_ready", {31'd0, s_ready}, 32'd1);

    // Table-driven windows
    for (int v = 0; v < 10; v++) begin
      target = vt[v].tgt;
      for (int k = 0; k < 4; k++) send(vt[v].re[k], vt[v].im[k]);
      wait_result();
      chk($sformatf("vec%0d m_mean", v), {16'd0, m_mean}, {16'd0, vt[v].mean});
      chk($sformatf("vec%0d m_low", v), {31'd0, m_low}, {31'd0, vt[v].low});
      chk($sformatf("vec%0d m_high", v), {31'd0, m_high}, {31'd0, vt[v].high});
      accept();
    end

    // Partial window discarded by reset
    send(8'h7F, 8'h00);
    send(8'h7F, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst m_mean", {16'd0, m_mean}, 32'd0);
    chk("midrst s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    target = 16'h0400;
    for (int i = 0; i < 4; i++) send(8'h20, 8'h00);
    wait_result();
    chk("after-rst m_mean", {16'd0, m_mean}, 32'h400);
    chk("after-rst m_low", {31'd0, m_low}, 32'd0);

    // Reset while in REPORT drops m_valid without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async m_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero crossings of re: -1, 1, -1, 1 gives two positive-going crossings
`ifdef QOSC_AMP_MON_ZC_EN
    zc_exp = 2'd2;
`else
    zc_exp = 2'd0;
`endif
    target = 16'h0001;
    send(8'hFF, 8'h00);
    send(8'h01, 8'h00);
    send(8'hFF, 8'h00);
    send(8'h01, 8'h00);
    wait_result();
    chk("zc m_zc_count", {30'd0, m_zc_count}, {30'd0, zc_exp});
    chk("zc m_mean", {16'd0, m_mean}, 32'd1);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
